// File: rtl/common_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Requester indices match bit positions of the request/grant vectors.
package common_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam int N_REQ     = 3;
  localparam int REQ_DBG   = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_DATA  = 2;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b001:  idx = 2'd0;
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational winner selection: debug first, then fetch/data round-robin.
// i_rr = 0 favours fetch, i_rr = 1 favours load/store.
module arb_pick
  import common_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_rr,
  output logic [N_REQ-1:0] o_win
);

  // Priority decode producing a one-hot winner
  always_comb begin
    o_win = 3'b000;
    if (i_req[REQ_DBG]) begin
      o_win[REQ_DBG] = 1'b1;
    end else if (i_req[REQ_FETCH] && (!i_req[REQ_DATA] || !i_rr)) begin
      o_win[REQ_FETCH] = 1'b1;
    end else if (i_req[REQ_DATA]) begin
      o_win[REQ_DATA] = 1'b1;
    end else begin
      o_win = 3'b000;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Three-requester arbiter for a single shared memory port.
// One transaction at a time: IDLE -> ACCESS -> (WAIT x N) -> RESP -> IDLE.
module mem_bus_arbiter
  import common_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [2:0]            i_req,
  input  logic [2:0]            i_we,
  input  logic [3*ADDR_W-1:0]   i_addr,
  input  logic [3*DATA_W-1:0]   i_wdata,
  output logic [2:0]            o_gnt,
  output logic [2:0]            o_done,
  output logic [DATA_W-1:0]     o_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  arb_state_t          state_r, state_nxt_s;
  logic [N_REQ-1:0]    pick_s, win_r, gnt_r, done_r;
  logic [1:0]          pick_idx_s;
  logic                sel_we_s, we_r, rr_r, mem_en_r, mem_we_r;
  logic [ADDR_W-1:0]   sel_addr_s, addr_r;
  logic [DATA_W-1:0]   sel_wdata_s, wdata_r, rdata_r;
  logic [3:0]          cnt_r;

  arb_pick u_pick (
    .i_req (i_req),
    .i_rr  (rr_r),
    .o_win (pick_s)
  );

  assign pick_idx_s = onehot_to_idx(pick_s);

  // Route the winning requester's command fields
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    case (pick_idx_s)
      2'd0: begin
        sel_we_s    = i_we[0];
        sel_addr_s  = i_addr[0*ADDR_W +: ADDR_W];
        sel_wdata_s = i_wdata[0*DATA_W +: DATA_W];
      end
      2'd1: begin
        sel_we_s    = i_we[1];
        sel_addr_s  = i_addr[1*ADDR_W +: ADDR_W];
        sel_wdata_s = i_wdata[1*DATA_W +: DATA_W];
      end
      2'd2: begin
        sel_we_s    = i_we[2];
        sel_addr_s  = i_addr[2*ADDR_W +: ADDR_W];
        sel_wdata_s = i_wdata[2*DATA_W +: DATA_W];
      end
      default: begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
      end
    endcase
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (|i_req) state_nxt_s = ACCESS;
        else        state_nxt_s = IDLE;
      end
      ACCESS: begin
        if (WAIT_CYCLES > 0) state_nxt_s = WAIT;
        else                 state_nxt_s = RESP;
      end
      WAIT: begin
        if (cnt_r + 4'd1 == WAIT_LAST) state_nxt_s = RESP;
        else                           state_nxt_s = WAIT;
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_r <= IDLE;
    else          state_r <= state_nxt_s;
  end

  // Transaction latch, wait counter, round-robin pointer and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win_r    <= 3'b000;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      rdata_r  <= '0;
      cnt_r    <= 4'd0;
      rr_r     <= 1'b0;
      gnt_r    <= 3'b000;
      done_r   <= 3'b000;
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
    end else begin
      gnt_r    <= 3'b000;
      done_r   <= 3'b000;
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|i_req) begin
            win_r    <= pick_s;
            we_r     <= sel_we_s;
            addr_r   <= sel_addr_s;
            wdata_r  <= sel_wdata_s;
            gnt_r    <= pick_s;
            mem_en_r <= 1'b1;
            mem_we_r <= sel_we_s;
            // Debug grants leave the fetch/data rotation untouched
            if (pick_s[REQ_FETCH])     rr_r <= 1'b1;
            else if (pick_s[REQ_DATA]) rr_r <= 1'b0;
          end
        end
        ACCESS: begin
          cnt_r <= 4'd0;
          if (WAIT_CYCLES == 0) begin
            done_r <= win_r;
            if (!we_r) rdata_r <= i_mem_rdata;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r + 4'd1;
          if (state_nxt_s == RESP) begin
            done_r <= win_r;
            if (!we_r) rdata_r <= i_mem_rdata;
          end
        end
        RESP:    ;
        default: ;
      endcase
    end
  end

  assign o_gnt       = gnt_r;
  assign o_done      = done_r;
  assign o_rdata     = rdata_r;
  assign o_mem_en    = mem_en_r;
  assign o_mem_we    = mem_we_r;
  assign o_mem_addr  = addr_r;
  assign o_mem_wdata = wdata_r;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, shall set the memory address width.
REQ-002 Parameter DATA_W, default 16, shall set the memory data width.
REQ-003 Parameter WAIT_CYCLES, default 0, range 0..15, shall set the memory read latency beyond one cycle.
REQ-004 Port i_clk, input, 1, shall be the single clock; all state updates on its rising edge.
REQ-005 Port i_rst_n, input, 1, shall be the reset: asynchronous, active-low.
REQ-006 Port i_req, input, 3, shall carry per-requester access requests: bit0 debug loader, bit1 instruction fetch, bit2 load/store.
REQ-007 Port i_we, input, 3, shall mark each request as a write (1) or a read (0).
REQ-008 Port i_addr, input, 3*ADDR_W, shall carry per-requester addresses, requester k in slice k.
REQ-009 Port i_wdata, input, 3*DATA_W, shall carry per-requester write data, requester k in slice k.
REQ-010 Port o_gnt, output, 3, shall be a one-hot grant pulse.
REQ-011 Port o_done, output, 3, shall be a one-hot completion pulse.
REQ-012 Port o_rdata, output, DATA_W, shall carry read data, valid while o_done is nonzero.
REQ-013 Ports o_mem_en (1), o_mem_we (1), o_mem_addr (ADDR_W), o_mem_wdata (DATA_W), outputs, shall drive the shared memory port.
REQ-014 Port i_mem_rdata, input, DATA_W, shall return memory read data.

Function
REQ-015 FSM states IDLE, ACCESS, WAIT, RESP; transitions IDLE->ACCESS when any i_req is set, ACCESS->WAIT if WAIT_CYCLES>0 else ACCESS->RESP, WAIT->RESP when the wait counter reaches WAIT_CYCLES, RESP->IDLE unconditionally.
REQ-016 Arbitration in IDLE: debug (bit0) has absolute priority; fetch and load/store share round-robin, with the winner of the last granted fetch-or-data transaction getting lowest priority next time.
REQ-017 The round-robin pointer shall be updated only on grants to fetch or load/store, never on debug grants.
REQ-018 On IDLE->ACCESS the block shall latch the winner index and that requester's we, addr and wdata; later changes to i_* shall not affect the transaction in flight.
REQ-019 In ACCESS, o_gnt[winner]=1 and o_mem_en=1 for exactly one cycle, with o_mem_we, o_mem_addr and o_mem_wdata driven from the latched values.
REQ-020 o_mem_en shall be 0 in every state other than ACCESS.
REQ-021 The wait counter shall be 4 bits, cleared on entry to WAIT, and increment by 1 per WAIT cycle.
REQ-022 Read data: i_mem_rdata shall be sampled on the edge leaving ACCESS (WAIT_CYCLES=0) or leaving the last WAIT cycle, then held in o_rdata.
REQ-023 In RESP, o_done[winner]=1 for exactly one cycle; for writes o_rdata retains its previous value.
REQ-024 Latency: a request first seen in IDLE at cycle t shall give o_gnt at t+1 and o_done at t+2+WAIT_CYCLES; one transaction per 3+WAIT_CYCLES cycles maximum.
REQ-025 A requester that drops i_req after grant shall still receive o_done, and the transaction shall complete.
REQ-026 Requests arriving outside IDLE shall be ignored until the next IDLE evaluation.
REQ-027 o_gnt and o_done shall never have more than one bit set, and never in the same cycle.

Reset
REQ-028 While i_rst_n=0: state shall be IDLE; o_gnt, o_done, o_mem_en and o_mem_we shall be 0; o_mem_addr, o_mem_wdata and o_rdata shall be 0.
REQ-029 In reset, the wait counter shall be 0 and the round-robin pointer shall favour fetch.
REQ-030 Reset asserted mid-transaction shall abort the transaction immediately with no o_done pulse; after release, arbitration shall restart from IDLE.

Structure
REQ-031 common_pkg shall hold the arb_state_t enum (IDLE, ACCESS, WAIT, RESP) and the constants N_REQ=3, REQ_DBG=0, REQ_FETCH=1, REQ_DATA=2.
REQ-032 A combinational sub-module arb_pick (inputs i_req and the round-robin pointer, output a one-hot winner) shall implement the priority logic; all sequential logic stays in mem_bus_arbiter.

Verification
REQ-033 With WAIT_CYCLES=0, a fetch read of addr 0x0010 with memory data 0xBEEF -> o_gnt=3'b010 one cycle after the request, then o_done=3'b010 with o_rdata=0xBEEF the next cycle.
REQ-034 With fetch and load/store requesting continuously from reset -> grants alternate 010, 100, 010, 100, spaced 3 cycles apart.
REQ-035 Debug request (0x0000, write 0x1234) raised together with fetch and load/store -> debug granted first, o_mem_we=1 and o_mem_wdata=0x1234 in ACCESS, round-robin order unchanged afterwards.
REQ-036 With WAIT_CYCLES=2, a load/store read -> o_done exactly 4 cycles after the request, o_rdata equal to i_mem_rdata of the last WAIT cycle.
REQ-037 Reset pulsed while in WAIT -> no o_done, all outputs 0, a pending request regranted 1 cycle after the first IDLE following release.
REQ-038 A requester dropping i_req the cycle after o_gnt -> o_done still pulses for that requester.
